// File: rtl/ysyx_23060136_ifu_bht.sv
// Branch history table: 2-bit saturating counters plus a direct-mapped target buffer.
// Combinational lookup for the fetch PC; trained by resolved branches from EXU2.
module ysyx_23060136_ifu_bht #(
    parameter int         INDEX_W  = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IFU_pc,
    output logic        IFU_pre_take,
    output logic [31:0] IFU_pre_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_pre_true,
    input  logic        upd_pre_false,
    input  logic        upd_pre_take,
    input  logic [31:0] upd_target,
    output logic [31:0] perf_true_cnt,
    output logic [31:0] perf_false_cnt
);

    localparam int TAG_W   = 32 - 2 - INDEX_W;
    localparam int ENTRIES = 1 << INDEX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      perf_true_q;
    logic [31:0]      perf_false_q;

    logic [INDEX_W-1:0] lkp_idx;
    logic [TAG_W-1:0]   lkp_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_legal;
    logic               upd_taken;
    logic [1:0]         upd_cnt;
    logic               unused_pc_bits;

    // Word-aligned PCs: the two low bits never select an entry.
    assign unused_pc_bits = ^{IFU_pc[1:0], upd_pc[1:0]};

    assign lkp_idx = IFU_pc[INDEX_W+1:2];
    assign lkp_tag = IFU_pc[31:INDEX_W+2];
    assign upd_idx = upd_pc[INDEX_W+1:2];
    assign upd_tag = upd_pc[31:INDEX_W+2];

    assign IFU_pre_take   = valid_q[lkp_idx] & (tag_q[lkp_idx] == lkp_tag) & cnt_q[lkp_idx][1];
    assign IFU_pre_target = target_q[lkp_idx];

    // Exactly one of correct/wrong must be flagged, otherwise the update is dropped.
    assign upd_legal = upd_valid & (upd_pre_true ^ upd_pre_false);
    assign upd_taken = upd_pre_true ? upd_pre_take : ~upd_pre_take;
    assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
    assign upd_cnt   = cnt_q[upd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
            perf_true_q  <= '0;
            perf_false_q <= '0;
        end else if (upd_legal) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    cnt_q[upd_idx]    <= (upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'b01;
                    target_q[upd_idx] <= upd_target;
                end else begin
                    cnt_q[upd_idx] <= (upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'b01;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch evicts whatever shares the index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                cnt_q[upd_idx]    <= 2'b10;
                target_q[upd_idx] <= upd_target;
            end
            if (upd_pre_true) begin
                if (perf_true_q != 32'hFFFF_FFFF) perf_true_q <= perf_true_q + 32'd1;
            end else begin
                if (perf_false_q != 32'hFFFF_FFFF) perf_false_q <= perf_false_q + 32'd1;
            end
        end
    end

    assign perf_true_cnt  = perf_true_q;
    assign perf_false_cnt = perf_false_q;

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// Scoreboard bench for the IFU branch history table: a behavioural model predicts
// each cycle's lookup and perf values, which are queued and compared mid-cycle.
module tb_ysyx_23060136_ifu_bht;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IFU_pc = 32'h8000_0000;
    logic        IFU_pre_take;
    logic [31:0] IFU_pre_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_pre_true = 1'b0;
    logic        upd_pre_false = 1'b0;
    logic        upd_pre_take = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic [31:0] perf_true_cnt;
    logic [31:0] perf_false_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        take;
        logic [31:0] target;
        logic [31:0] ptrue;
        logic [31:0] pfalse;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the table, INDEX_W = 4.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [1:0]  m_cnt   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_true;
    logic [31:0] m_false;

    ysyx_23060136_ifu_bht dut (
        .clk            (clk),
        .rst            (rst),
        .IFU_pc         (IFU_pc),
        .IFU_pre_take   (IFU_pre_take),
        .IFU_pre_target (IFU_pre_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_pre_true   (upd_pre_true),
        .upd_pre_false  (upd_pre_false),
        .upd_pre_take   (upd_pre_take),
        .upd_target     (upd_target),
        .perf_true_cnt  (perf_true_cnt),
        .perf_false_cnt (perf_false_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 2'b01;
        end
        m_true  = 32'd0;
        m_false = 32'd0;
    endtask

    task automatic modelUpdate(input logic r, input logic uv, input logic [31:0] upc,
                               input logic pt, input logic pf, input logic tk,
                               input logic [31:0] tgt);
        int  i;
        bit  hit;
        bit  dir;
        if (r) begin
            modelReset();
            return;
        end
        if (!(uv && (pt != pf))) return;
        i   = int'(upc[5:2]);
        hit = m_valid[i] && (m_tag[i] == upc[31:6]);
        dir = pt ? tk : !tk;
        if (hit) begin
            if (dir) begin
                if (m_cnt[i] != 2'd3) m_cnt[i] = m_cnt[i] + 2'd1;
                m_tgt[i] = tgt;
            end else if (m_cnt[i] != 2'd0) begin
                m_cnt[i] = m_cnt[i] - 2'd1;
            end
        end else if (dir) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = upc[31:6];
            m_cnt[i]   = 2'b10;
            m_tgt[i]   = tgt;
        end
        if (pt) begin
            if (m_true != 32'hFFFF_FFFF) m_true = m_true + 32'd1;
        end else if (m_false != 32'hFFFF_FFFF) begin
            m_false = m_false + 32'd1;
        end
    endtask

    task automatic sampleDut();
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        checkOutput("pre_take", {31'd0, IFU_pre_take}, {31'd0, e.take});
        if (e.take) checkOutput("pre_target", IFU_pre_target, e.target);
        checkOutput("perf_true", perf_true_cnt, e.ptrue);
        checkOutput("perf_false", perf_false_cnt, e.pfalse);
    endtask

    // One cycle: drive at negedge, queue the model's prediction, sample, then advance.
    task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic uv,
                                 input logic [31:0] upc, input logic pt, input logic pf,
                                 input logic tk, input logic [31:0] tgt);
        exp_t e;
        int   i;
        rst = r; IFU_pc = pc; upd_valid = uv; upd_pc = upc;
        upd_pre_true = pt; upd_pre_false = pf; upd_pre_take = tk; upd_target = tgt;
        i        = int'(pc[5:2]);
        e.take   = m_valid[i] && (m_tag[i] == pc[31:6]) && m_cnt[i][1];
        e.target = m_tgt[i];
        e.ptrue  = m_true;
        e.pfalse = m_false;
        sb_q.push_back(e);
        #2;
        sampleDut();
        @(posedge clk);
        modelUpdate(r, uv, upc, pt, pf, tk, tgt);
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic update(input logic [31:0] pc, input logic pt, input logic pf,
                          input logic tk, input logic [31:0] tgt);
        applyStimulus(1'b0, pc, 1'b1, pc, pt, pf, tk, tgt);
    endtask

    initial begin
        logic [31:0] pcs [8];
        modelReset();
        for (int i = 0; i < 16; i++) begin
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] reset sweep");
        for (int i = 0; i < 16; i++) lookup(32'h8000_0000 + 32'(i * 4));

        $display("[TB] allocate then hit");
        update(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h8000_0100);
        lookup(32'h8000_0010);

        $display("[TB] saturation");
        update(32'h8000_0010, 1'b1, 1'b0, 1'b1, 32'h8000_0100);
        update(32'h8000_0010, 1'b1, 1'b0, 1'b1, 32'h8000_0100);
        for (int k = 0; k < 3; k++) update(32'h8000_0010, 1'b1, 1'b0, 1'b0, 32'h8000_0104);
        lookup(32'h8000_0010);

        $display("[TB] alias and tag mismatch");
        update(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h8000_0108);
        update(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h8000_0108);
        lookup(32'h8000_0010);
        lookup(32'h8000_0050);
        update(32'h8000_0050, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
        lookup(32'h8000_0050);
        lookup(32'h8000_0010);

        $display("[TB] illegal and gated updates");
        for (int k = 0; k < 2; k++) update(32'h8000_0050, 1'b1, 1'b1, 1'b0, 32'h8000_0300);
        for (int k = 0; k < 2; k++) update(32'h8000_0050, 1'b0, 1'b0, 1'b0, 32'h8000_0300);
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b0, 32'h8000_0050, 1'b0, 32'h8000_0050, 1'b0, 1'b1, 1'b1, 32'h8000_0300);
        lookup(32'h8000_0050);

        $display("[TB] same-cycle read/write, reset priority");
        update(32'h8000_0020, 1'b1, 1'b0, 1'b1, 32'h8000_0400);
        lookup(32'h8000_0020);
        applyStimulus(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0020, 1'b1, 1'b0, 1'b1, 32'h8000_0400);
        for (int i = 0; i < 16; i++) lookup(32'h8000_0000 + 32'(i * 4));
        for (int i = 0; i < 16; i++) lookup(32'h8000_0040 + 32'(i * 4));

        $display("[TB] random training");
        for (int i = 0; i < 4; i++) begin
            pcs[i]     = 32'h8000_0000 + 32'(i * 4);
            pcs[i + 4] = 32'h8000_0040 + 32'(i * 4);
        end
        for (int k = 0; k < 300; k++) begin
            logic [31:0] rtgt;
            rtgt = {$urandom()} & 32'hFFFF_FFFC;
            applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                          pcs[$urandom_range(0, 7)],
                          1'($urandom_range(0, 3) != 0),
                          pcs[$urandom_range(0, 7)],
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), rtgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
